vga_timing_generator: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 37 +++
 rtl/vga_axis_counter.sv | 67 ++++++
 rtl/vga_timing_generator.sv | 115 +++++++++++
 tb/tb_vga_timing_generator.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA timing generator.
// Defaults describe standard 640x480@60 timing.
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FRONT  = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BACK   = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FRONT  = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BACK   = 33;
  localparam int unsigned DEF_CW       = 11;

  // Full length of one axis: visible region plus all blanking pieces.
  function automatic int unsigned axis_total(input int unsigned active, input int unsigned front,
                                             input int unsigned sync, input int unsigned back);
    return active + front + sync + back;
  endfunction

  // First position at which the sync pulse is asserted.
  function automatic int unsigned sync_first(input int unsigned active, input int unsigned front);
    return active + front;
  endfunction

  // Last position (inclusive) at which the sync pulse is asserted.
  function automatic int unsigned sync_last(input int unsigned active, input int unsigned front,
                                            input int unsigned sync);
    return active + front + sync - 1;
  endfunction

  // True when an unsigned counter of the given width can represent value.
  function automatic bit fits_width(input int unsigned value, input int unsigned width);
    return (width >= 32) || (value < (32'd1 << width));
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter plus its sync decode.
// Exposes the next count and its active decode so the parent can register
// outputs that line up with the counter without extra latency.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned FRONT    = DEF_H_FRONT,
  parameter int unsigned SYNC     = DEF_H_SYNC,
  parameter int unsigned BACK     = DEF_H_BACK,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned CW       = DEF_CW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          tick_i,
  output logic          wrap_o,
  output logic [CW-1:0] cnt_next_o,
  output logic          active_next_o,
  output logic          sync_o
);

  localparam int unsigned   TOTAL      = axis_total(ACTIVE, FRONT, SYNC, BACK);
  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACTIVE_END = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_FIRST = CW'(sync_first(ACTIVE, FRONT));
  localparam logic [CW-1:0] SYNC_LAST  = CW'(sync_last(ACTIVE, FRONT, SYNC));

  if (SYNC == 0) begin : g_bad_sync
    $error("vga_axis_counter: sync width must be non-zero");
  end

  if (!fits_width(TOTAL - 1, CW)) begin : g_bad_cw
    $error("vga_axis_counter: CW too narrow for axis total");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync_q, sync_d;
  logic          wrap;

  // Advance on tick, wrap at the end of the axis, decode the upcoming position.
  always_comb begin
    wrap  = tick_i && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (tick_i) begin
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
    end
    active_next_o = (cnt_d < ACTIVE_END);
    sync_d        = ((cnt_d >= SYNC_FIRST) && (cnt_d <= SYNC_LAST)) ? SYNC_POL : ~SYNC_POL;
  end

  // Reset parks the counter on its last position so the first tick lands on 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= LAST;
      sync_q <= ~SYNC_POL;
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= sync_d;
    end
  end

  assign wrap_o     = wrap;
  assign cnt_next_o = cnt_d;
  assign sync_o     = sync_q;

endmodule

// File: rtl/vga_timing_generator.sv
// Parametrised VGA timing generator running on a system clock with a
// pixel-enable qualifier. All outputs are registered from the decode of the
// next counter position, so they describe the current position directly.
module vga_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT    = DEF_H_FRONT,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BACK     = DEF_H_BACK,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT    = DEF_V_FRONT,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BACK     = DEF_V_BACK,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned CW         = DEF_CW
) (
  input  logic          block_clk_i,
  input  logic          rst_low_i,
  input  logic          pix_en_i,
  output logic          h_sync_o,
  output logic          v_sync_o,
  output logic          active_o,
  output logic          vblank_o,
  output logic [CW-1:0] pix_x_o,
  output logic [CW-1:0] pix_y_o,
  output logic          line_start_o,
  output logic          frame_start_o
);

  logic          h_wrap, v_wrap;
  logic          h_active_next, v_active_next;
  logic [CW-1:0] h_next, v_next;

  vga_axis_counter #(
    .ACTIVE   (H_ACTIVE),
    .FRONT    (H_FRONT),
    .SYNC     (H_SYNC),
    .BACK     (H_BACK),
    .SYNC_POL (H_SYNC_POL),
    .CW       (CW)
  ) u_h_axis (
    .clk_i         (block_clk_i),
    .rst_ni        (rst_low_i),
    .tick_i        (pix_en_i),
    .wrap_o        (h_wrap),
    .cnt_next_o    (h_next),
    .active_next_o (h_active_next),
    .sync_o        (h_sync_o)
  );

  // The vertical axis only moves when a line finishes, so v_sync can only
  // change on a horizontal wrap.
  vga_axis_counter #(
    .ACTIVE   (V_ACTIVE),
    .FRONT    (V_FRONT),
    .SYNC     (V_SYNC),
    .BACK     (V_BACK),
    .SYNC_POL (V_SYNC_POL),
    .CW       (CW)
  ) u_v_axis (
    .clk_i         (block_clk_i),
    .rst_ni        (rst_low_i),
    .tick_i        (h_wrap),
    .wrap_o        (v_wrap),
    .cnt_next_o    (v_next),
    .active_next_o (v_active_next),
    .sync_o        (v_sync_o)
  );

  logic          active_q, active_d;
  logic          vblank_q, vblank_d;
  logic [CW-1:0] pix_x_q, pix_x_d;
  logic [CW-1:0] pix_y_q, pix_y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  // Decode the combined position; strobes only fire on the tick that wraps.
  always_comb begin
    active_d      = h_active_next && v_active_next;
    vblank_d      = ~v_active_next;
    pix_x_d       = active_d ? h_next : '0;
    pix_y_d       = active_d ? v_next : '0;
    line_start_d  = h_wrap;
    frame_start_d = v_wrap;
  end

  // Output registers; reset matches the parked last back-porch position.
  always_ff @(posedge block_clk_i or negedge rst_low_i) begin
    if (!rst_low_i) begin
      active_q      <= 1'b0;
      vblank_q      <= 1'b1;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      active_q      <= active_d;
      vblank_q      <= vblank_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign active_o      = active_q;
  assign vblank_o      = vblank_q;
  assign pix_x_o       = pix_x_q;
  assign pix_y_o       = pix_y_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Self-checking bench for vga_timing_generator: a small 8x6 instance driven
// from a vector table and hand-written sequences, plus a default 640x480
// instance with positive sync polarity checked over its first two lines.
module tb_vga_timing_generator;

  localparam int CW = 11;

  logic clk = 1'b0;
  logic rst_low = 1'b1;
  logic pix_en = 1'b0;
  logic big_rst_low = 1'b1;
  logic big_en = 1'b1;

  logic          h_sync, v_sync, active, vblank, line_start, frame_start;
  logic [CW-1:0] pix_x, pix_y;
  logic          b_h_sync, b_v_sync, b_active, b_vblank, b_line_start, b_frame_start;
  logic [CW-1:0] b_pix_x, b_pix_y;

  int test_count = 0;
  int fail_count = 0;

  always #5 clk = ~clk;

  vga_timing_generator #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .CW(CW)
  ) dut (
    .block_clk_i   (clk),
    .rst_low_i     (rst_low),
    .pix_en_i      (pix_en),
    .h_sync_o      (h_sync),
    .v_sync_o      (v_sync),
    .active_o      (active),
    .vblank_o      (vblank),
    .pix_x_o       (pix_x),
    .pix_y_o       (pix_y),
    .line_start_o  (line_start),
    .frame_start_o (frame_start)
  );

  vga_timing_generator #(
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) dut_big (
    .block_clk_i   (clk),
    .rst_low_i     (big_rst_low),
    .pix_en_i      (big_en),
    .h_sync_o      (b_h_sync),
    .v_sync_o      (b_v_sync),
    .active_o      (b_active),
    .vblank_o      (b_vblank),
    .pix_x_o       (b_pix_x),
    .pix_y_o       (b_pix_y),
    .line_start_o  (b_line_start),
    .frame_start_o (b_frame_start)
  );

  // Packed view used for all comparisons: {hs, vs, act, vb, ls, fs, x, y}.
  function automatic logic [27:0] pk(input int hs, input int vs, input int act, input int vb,
                                     input int ls, input int fs, input int x, input int y);
    return {1'(hs), 1'(vs), 1'(act), 1'(vb), 1'(ls), 1'(fs), 11'(x), 11'(y)};
  endfunction

  // Expected outputs of the small instance at position (h, v).
  function automatic logic [27:0] expSmall(input int h, input int v, input int tick);
    int act;
    act = ((h < 4) && (v < 3)) ? 1 : 0;
    return pk((h >= 5 && h <= 6) ? 0 : 1, (v == 4) ? 0 : 1, act, (v >= 3) ? 1 : 0,
              (tick != 0 && h == 0) ? 1 : 0, (tick != 0 && h == 0 && v == 0) ? 1 : 0,
              (act != 0) ? h : 0, (act != 0) ? v : 0);
  endfunction

  // Expected outputs of the default instance (positive polarity syncs).
  function automatic logic [27:0] expBig(input int h, input int v);
    int act;
    act = ((h < 640) && (v < 480)) ? 1 : 0;
    return pk((h >= 656 && h < 752) ? 1 : 0, (v >= 490 && v < 492) ? 1 : 0, act,
              (v >= 480) ? 1 : 0, (h == 0) ? 1 : 0, (h == 0 && v == 0) ? 1 : 0,
              (act != 0) ? h : 0, (act != 0) ? v : 0);
  endfunction

  function automatic logic [27:0] smallOut();
    return {h_sync, v_sync, active, vblank, line_start, frame_start, pix_x, pix_y};
  endfunction

  function automatic logic [27:0] bigOut();
    return {b_h_sync, b_v_sync, b_active, b_vblank, b_line_start, b_frame_start, b_pix_x, b_pix_y};
  endfunction

  // Drive one cycle of inputs, then return at the following falling edge.
  task automatic applyStimulus(input logic rst_v, input logic en_v);
    rst_low = rst_v;
    pix_en  = en_v;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [27:0] got, input logic [27:0] want);
    test_count++;
    if (got !== want) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        en;
    logic [27:0] exp;
  } vec_t;

  vec_t vecs [16];

  initial begin
    int h, v, hs_low, vs_low, act_cnt, fs_cnt, ls_cnt, fs_first, fs_second;
    logic en_v;

    // Reset state, first tick, stalls and the first line boundary.
    vecs[0]  = '{1'b0, 1'b0, pk(1,1,0,1,0,0,0,0)};
    vecs[1]  = '{1'b0, 1'b1, pk(1,1,0,1,0,0,0,0)};
    vecs[2]  = '{1'b1, 1'b0, pk(1,1,0,1,0,0,0,0)};
    vecs[3]  = '{1'b1, 1'b1, pk(1,1,1,0,1,1,0,0)};
    vecs[4]  = '{1'b1, 1'b0, pk(1,1,1,0,0,0,0,0)};
    vecs[5]  = '{1'b1, 1'b1, pk(1,1,1,0,0,0,1,0)};
    vecs[6]  = '{1'b1, 1'b1, pk(1,1,1,0,0,0,2,0)};
    vecs[7]  = '{1'b1, 1'b1, pk(1,1,1,0,0,0,3,0)};
    vecs[8]  = '{1'b1, 1'b1, pk(1,1,0,0,0,0,0,0)};
    vecs[9]  = '{1'b1, 1'b1, pk(0,1,0,0,0,0,0,0)};
    vecs[10] = '{1'b1, 1'b0, pk(0,1,0,0,0,0,0,0)};
    vecs[11] = '{1'b1, 1'b1, pk(0,1,0,0,0,0,0,0)};
    vecs[12] = '{1'b1, 1'b1, pk(1,1,0,0,0,0,0,0)};
    vecs[13] = '{1'b1, 1'b1, pk(1,1,1,0,1,0,0,1)};
    vecs[14] = '{1'b1, 1'b1, pk(1,1,1,0,0,0,1,1)};
    vecs[15] = '{1'b1, 1'b1, pk(1,1,1,0,0,0,2,1)};

    #1;
    rst_low     = 1'b0;
    big_rst_low = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].en);
      checkOutput($sformatf("vec%0d", i), smallOut(), vecs[i].exp);
    end

    // Asynchronous reset mid-line at (2,1), between clock edges.
    #2;
    rst_low = 1'b0;
    #1;
    checkOutput("async_reset", smallOut(), pk(1,1,0,1,0,0,0,0));
    applyStimulus(1'b0, 1'b1);
    checkOutput("async_reset_held", smallOut(), pk(1,1,0,1,0,0,0,0));
    applyStimulus(1'b1, 1'b1);
    checkOutput("restart_frame_start", smallOut(), pk(1,1,1,0,1,1,0,0));
    applyStimulus(1'b1, 1'b0);
    checkOutput("restart_strobe_clear", smallOut(), pk(1,1,1,0,0,0,0,0));

    // Two frames with pixel enable held high.
    applyStimulus(1'b0, 1'b0);
    h = 7; v = 5;
    hs_low = 0; vs_low = 0; act_cnt = 0; fs_cnt = 0; fs_first = -1; fs_second = -1;
    for (int i = 0; i < 96; i++) begin
      if (h == 7) begin h = 0; v = (v == 5) ? 0 : v + 1; end else h++;
      applyStimulus(1'b1, 1'b1);
      checkOutput($sformatf("cont_t%0d", i), smallOut(), expSmall(h, v, 1));
      if (h_sync == 1'b0) hs_low++;
      if (v_sync == 1'b0) vs_low++;
      if (active) act_cnt++;
      if (frame_start) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = i; else if (fs_second < 0) fs_second = i;
      end
    end
    checkOutput("cont_hsync_low_count", 28'(hs_low), 28'd24);
    checkOutput("cont_vsync_low_count", 28'(vs_low), 28'd16);
    checkOutput("cont_active_count", 28'(act_cnt), 28'd24);
    checkOutput("cont_frame_count", 28'(fs_cnt), 28'd2);
    checkOutput("cont_frame_period", 28'(fs_second - fs_first), 28'd48);

    // Two frames with a tick every third cycle; outputs hold between ticks.
    applyStimulus(1'b0, 1'b0);
    h = 7; v = 5;
    act_cnt = 0; fs_cnt = 0; ls_cnt = 0;
    for (int i = 0; i < 288; i++) begin
      en_v = (i % 3 == 0);
      if (en_v) begin
        if (h == 7) begin h = 0; v = (v == 5) ? 0 : v + 1; end else h++;
      end
      applyStimulus(1'b1, en_v);
      checkOutput($sformatf("slow_c%0d", i), smallOut(), expSmall(h, v, en_v ? 1 : 0));
      if (active) act_cnt++;
      if (frame_start) fs_cnt++;
      if (line_start) ls_cnt++;
    end
    checkOutput("slow_active_count", 28'(act_cnt), 28'd72);
    checkOutput("slow_frame_count", 28'(fs_cnt), 28'd2);
    checkOutput("slow_line_count", 28'(ls_cnt), 28'd12);

    // Default 640x480 timing, positive polarity, first two lines.
    checkOutput("big_reset", bigOut(), pk(0,0,0,1,0,0,0,0));
    big_rst_low = 1'b1;
    h = 799; v = 524;
    hs_low = 0; act_cnt = 0;
    for (int i = 0; i < 1600; i++) begin
      if (h == 799) begin h = 0; v = (v == 524) ? 0 : v + 1; end else h++;
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("big_t%0d", i), bigOut(), expBig(h, v));
      if (b_h_sync) hs_low++;
      if (b_active) act_cnt++;
    end
    checkOutput("big_hsync_high_count", 28'(hs_low), 28'd192);
    checkOutput("big_active_count", 28'(act_cnt), 28'd1280);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
